// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, word-addressed instruction memory, and the
// IF/ID pipeline register feeding decode. Redirects from MEM take priority over stalls.
module fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          pcsrc,
    input  logic [31:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   if_id_ir,
    output logic [31:0]                   if_id_npc,
    output logic                          if_id_valid,
    output logic [31:0]                   fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
        logic        valid;
    } if_id_t;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] count_q;
    logic [31:0] count_next;
    if_id_t      if_id_q;
    if_id_t      if_id_next;

    // Target bits [1:0] are always forced to zero on a redirect.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    // PC bits above the index are dropped, so fetches wrap around the memory.
    assign fetch_word = imem[pc[AW+1:2]];
    assign pc_plus4   = pc + 32'd4;

    always_comb begin
        pc_next    = pc;
        if_id_next = if_id_q;
        count_next = count_q;
        if (pcsrc) begin
            pc_next          = {branch_target[31:2], 2'b00};
            if_id_next.ir    = 32'h0000_0000;
            if_id_next.npc   = 32'h0000_0000;
            if_id_next.valid = 1'b0;
        end else if (!stall) begin
            pc_next          = pc_plus4;
            if_id_next.ir    = fetch_word;
            if_id_next.npc   = pc_plus4;
            if_id_next.valid = 1'b1;
            count_next       = count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let one register see another's new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            if_id_q <= '0;
            count_q <= '0;
        end else begin
            pc      <= pc_next;
            if_id_q <= if_id_next;
            count_q <= count_next;
        end
    end

    // NOTE: the memory array is deliberately left out of reset so its contents survive
    // a reset and it maps onto plain RAM. A same-edge write is seen by the next read only,
    // so a colliding fetch gets the old word.
    always_ff @(posedge clk) begin
        if (imem_we && !reset) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    assign if_id_ir    = if_id_q.ir;
    assign if_id_npc   = if_id_q.npc;
    assign if_id_valid = if_id_q.valid;
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words; power of two, 4..1024.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] are zero.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; clock is clk, reset is reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold request from the hazard logic; freezes PC and IF/ID.
REQ-007 pcsrc  input  1  taken-branch redirect from the MEM stage.
REQ-008 branch_target  input  32  redirect PC, valid when pcsrc=1.
REQ-009 imem_we  input  1  instruction-memory load strobe.
REQ-010 imem_waddr  input  log2(IMEM_DEPTH)  word address for the load.
REQ-011 imem_wdata  input  32  word written on imem_we.
REQ-012 pc  output  32  current fetch PC.
REQ-013 if_id_ir  output  32  IF/ID instruction register, consumed by decode.
REQ-014 if_id_npc  output  32  IF/ID next-PC, equal to fetch PC+4.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-016 fetch_count  output  32  number of instructions latched into IF/ID since reset.

Function
REQ-017 Instruction memory SHALL be IMEM_DEPTH x 32; read is combinational at index pc[log2(IMEM_DEPTH)+1:2].
REQ-018 PC bits above the index SHALL be ignored, so fetch addresses wrap modulo 4*IMEM_DEPTH bytes.
REQ-019 An imem write SHALL be synchronous on the rising edge of clk.
REQ-020 A fetch from the address being written in the same cycle SHALL return the old word.
REQ-021 Priority per edge SHALL be: reset, then pcsrc, then stall, then normal advance.
REQ-022 Normal advance, with pcsrc=0 and stall=0:
- pc <= pc+4, wrapping modulo 2^32.
- if_id_ir <= imem[index].
- if_id_npc <= pc+4.
- if_id_valid <= 1.
- fetch_count <= fetch_count+1.
REQ-023 Stall, with pcsrc=0 and stall=1: pc, if_id_ir, if_id_npc, if_id_valid and fetch_count SHALL hold.
REQ-024 Redirect, with pcsrc=1 regardless of stall:
- pc <= {branch_target[31:2],2'b00}; low two bits are forced to zero.
- if_id_ir <= 32'h0000_0000 (NOP).
- if_id_npc <= 0.
- if_id_valid <= 0.
- fetch_count holds.
REQ-025 On the first edge after a redirect, the instruction at the target SHALL enter IF/ID, with latency one cycle from target to IF/ID.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 A stall asserted for N consecutive cycles SHALL delay the sequence by exactly N cycles with no lost or duplicated instruction.
REQ-028 imem writes SHALL be accepted during stall, redirect and reset-deasserted idle cycles alike.
REQ-029 All outputs SHALL be registered except none; pc is the PC register itself.

Reset
REQ-030 On reset assertion, asynchronously and without waiting for clk:
- pc = RESET_PC.
- if_id_ir = 0.
- if_id_npc = 0.
- if_id_valid = 0.
- fetch_count = 0.
REQ-031 Reset SHALL NOT clear instruction-memory contents.
REQ-032 imem writes SHALL be ignored while reset=1.
REQ-033 Reset asserted mid-operation, including during a stall or redirect, SHALL discard in-flight state; the first edge after deassertion fetches from RESET_PC.

Verification
REQ-034 Sequential fetch:
- Stimulus: load imem[0..3] = 11,22,33,44; release reset; run 4 edges.
- Required: if_id_ir = 11,22,33,44; if_id_npc = 4,8,12,16; pc = 16; fetch_count = 4.
REQ-035 Stall:
- Stimulus: after the second fetch (ir=22), hold stall=1 for 3 edges, then release.
- Required: ir=22 and pc=8 throughout the stall; next ir=33; fetch_count increments only on non-stall edges.
REQ-036 Redirect over stall:
- Stimulus: stall=1, pcsrc=1, branch_target=32'h0000_000E.
- Required: pc=12, if_id_valid=0, if_id_ir=0; next edge ir=imem[3]=44, valid=1.
REQ-037 Wrap:
- Stimulus: IMEM_DEPTH=64; redirect to 32'h0000_00FC, then advance 2 edges.
- Required: ir=imem[63], then ir=imem[0]; pc=32'h0000_0104.
REQ-038 Async reset:
- Stimulus: assert reset between clock edges during a run.
- Required: all outputs at reset values immediately, before the next edge; imem contents intact; refetch from RESET_PC.
REQ-039 Write/read collision:
- Stimulus: imem_we=1, imem_waddr = current index, wdata=32'hDEAD_BEEF on a fetching edge.
- Required: IF/ID gets the old word; a later fetch of that address returns 32'hDEAD_BEEF.
